// File: rtl/logic_gates_pkg.sv
// logic_gates_pkg: gate bit map, checker states and the golden gate function
package logic_gates_pkg;
    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOT  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;
    localparam int GATE_W    = 7;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic logic [GATE_W-1:0] gate_expect(input logic a, input logic b);
        logic [GATE_W-1:0] e;
        e[GATE_AND]  = a & b;
        e[GATE_OR]   = a | b;
        e[GATE_NOT]  = ~a;
        e[GATE_NAND] = ~(a & b);
        e[GATE_NOR]  = ~(a | b);
        e[GATE_XOR]  = a ^ b;
        e[GATE_XNOR] = ~(a ^ b);
        return e;
    endfunction
endpackage

// File: rtl/logic_gates_checker_if.sv
// logic_gates_checker_if: stimulus samples in, run results out
interface logic_gates_checker_if #(parameter int CNT_W = 8);
    import logic_gates_pkg::*;
    logic              start;
    logic              sample_valid;
    logic              a;
    logic              b;
    logic [GATE_W-1:0] gate_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  pass_count;
    logic [CNT_W-1:0]  fail_count;
    logic [1:0]        first_fail_vec;
    logic [GATE_W-1:0] first_fail_mask;
    logic              fail_seen;
    modport master (
        output start, sample_valid, a, b, gate_out,
        input  busy, done, pass, pass_count, fail_count, first_fail_vec, first_fail_mask, fail_seen
    );
    modport slave (
        input  start, sample_valid, a, b, gate_out,
        output busy, done, pass, pass_count, fail_count, first_fail_vec, first_fail_mask, fail_seen
    );
endinterface

// File: rtl/logic_gates_ref.sv
// logic_gates_ref: combinational golden model of the seven gate outputs
module logic_gates_ref
    import logic_gates_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [GATE_W-1:0] expect_out
);
    assign expect_out = gate_expect(a, b);
endmodule

// File: rtl/logic_gates_checker.sv
// logic_gates_checker: pipelined golden-model check of gate responses with pass/fail counters
module logic_gates_checker
    import logic_gates_pkg::*;
#(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input logic                  clk,
    input logic                  rst,
    logic_gates_checker_if.slave bus
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] NUM = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] MAX = '1;
    state_t            state, state_next;
    logic              s1_valid, s1_a, s1_b;
    logic [GATE_W-1:0] s1_out, exp_out;
    logic [CNT_W-1:0]  vec_cnt, pass_cnt, fail_cnt, vec_next, pass_next, fail_next;
    logic              pass_q, fail_seen_q;
    logic [1:0]        ff_vec;
    logic [GATE_W-1:0] ff_mask;
    logic              accept, check, mismatch, last, clear;
    logic_gates_ref u_ref (.a(s1_a), .b(s1_b), .expect_out(exp_out));
    // case inequality flags X/Z on gate_out as a mismatch in simulation
    assign mismatch = s1_out !== exp_out;
    assign check    = s1_valid && state == RUN;
    // the in-flight stage-1 sample counts toward the run length, so extras are refused
    assign accept   = bus.sample_valid && state == RUN && (vec_cnt + (s1_valid ? ONE : '0)) < NUM;
    assign clear    = bus.start && state != RUN;
    always_comb begin
        vec_next   = (check && vec_cnt != MAX) ? vec_cnt + ONE : vec_cnt;
        pass_next  = (check && !mismatch && pass_cnt != MAX) ? pass_cnt + ONE : pass_cnt;
        fail_next  = (check && mismatch && fail_cnt != MAX) ? fail_cnt + ONE : fail_cnt;
        last       = check && vec_next == NUM;
        state_next = state != RUN ? (bus.start ? RUN : state) : (last ? DONE : RUN);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_a        <= 1'b0;
            s1_b        <= 1'b0;
            s1_out      <= '0;
            vec_cnt     <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            ff_vec      <= '0;
            ff_mask     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= bus.a;
                s1_b   <= bus.b;
                s1_out <= bus.gate_out;
            end
            if (clear) begin
                vec_cnt     <= '0;
                pass_cnt    <= '0;
                fail_cnt    <= '0;
                pass_q      <= 1'b0;
                fail_seen_q <= 1'b0;
                ff_vec      <= '0;
                ff_mask     <= '0;
            end else if (check) begin
                vec_cnt  <= vec_next;
                pass_cnt <= pass_next;
                fail_cnt <= fail_next;
                if (mismatch && !fail_seen_q) begin
                    fail_seen_q <= 1'b1;
                    ff_vec      <= {s1_a, s1_b};
                    ff_mask     <= exp_out ^ s1_out;
                end
                if (last) pass_q <= fail_next == '0;
            end
        end
    end
    assign bus.busy            = state == RUN;
    assign bus.done            = state == DONE;
    assign bus.pass            = pass_q;
    assign bus.pass_count      = pass_cnt;
    assign bus.fail_count      = fail_cnt;
    assign bus.first_fail_vec  = ff_vec;
    assign bus.first_fail_mask = ff_mask;
    assign bus.fail_seen       = fail_seen_q;
endmodule
